multicycle_control: RTL and testbench

- Moore FSM main control unit for the multicycle RV32I datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps.
- Drives the datapath strobes and mux selects, and produces the 2-bit alu_op consumed by the ALU control decoder.
- Waits on a ready/request handshake with the unified instruction/data memory.

---
 rtl/multicycle_pkg.sv | 57 +++++
 rtl/multicycle_control_if.sv | 10 +
 rtl/multicycle_ctrl_outputs.sv | 75 +++++++
 rtl/multicycle_control.sv | 103 ++++++++++
 tb/tb_multicycle_control.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle RV32I main control unit:
// states, opcodes, mux selects and the per-state control vector.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9,
    S_JAL    = 4'd10
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  // fetch marks the strobes the parent qualifies with mem_ready
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       fetch;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Unified instruction/data memory request/ready handshake.
interface multicycle_control_if;
  logic mem_req;
  logic mem_write;
  logic adr_src;
  logic mem_ready;

  modport master (output mem_req, output mem_write, output adr_src, input mem_ready);
  modport slave  (input mem_req, input mem_write, input adr_src, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl_outputs.sv
// Moore output decode: maps the current state onto the raw control vector.
module multicycle_ctrl_outputs
  import multicycle_pkg::*;
(
  input  state_e state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req    = 1'b1;
        ctrl.fetch      = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_MEMDATA;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.adr_src   = 1'b1;
      end
      S_EXECR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.branch     = 1'b1;
      end
      S_JAL: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_update  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I main control FSM: state register, next-state decode and
// reset-gated outputs. Optional retired-instruction counter: INSTRET_CNT_EN.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [6:0]           opcode,
  input  logic                 zero,
  multicycle_control_if.master mem,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           result_src,
  output logic                 illegal_instr
`ifdef INSTRET_CNT_EN
  ,
  output logic [CNT_W-1:0]     instret
`endif
);

  state_e state_q, state_d;
  ctrl_t  ctrl;
  logic   dec_illegal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    dec_illegal = 1'b0;
    case (state_q)
      S_FETCH:  if (mem.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default: begin
            state_d     = S_FETCH;
            dec_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem.mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem.mem_ready) state_d = S_FETCH;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      S_JAL:    state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
  end

  multicycle_ctrl_outputs u_outputs (
    .state (state_q),
    .ctrl  (ctrl)
  );

  // Everything is gated by reset_n so an in-flight request drops the moment
  // reset asserts, without waiting for a clock.
  assign mem.mem_req   = reset_n & ctrl.mem_req;
  assign mem.mem_write = reset_n & ctrl.mem_write;
  assign mem.adr_src   = reset_n & ctrl.adr_src;
  assign ir_write      = reset_n & ctrl.fetch & mem.mem_ready;
  assign pc_write      = reset_n & ((ctrl.fetch & mem.mem_ready) | ctrl.pc_update
                                    | (ctrl.branch & zero));
  assign reg_write     = reset_n & ctrl.reg_write;
  assign alu_src_a     = reset_n ? ctrl.alu_src_a  : 2'b00;
  assign alu_src_b     = reset_n ? ctrl.alu_src_b  : 2'b00;
  assign alu_op        = reset_n ? ctrl.alu_op     : 2'b00;
  assign result_src    = reset_n ? ctrl.result_src : 2'b00;
  assign illegal_instr = reset_n & dec_illegal;

`ifdef INSTRET_CNT_EN
  logic [CNT_W-1:0] instret_q, instret_d;

  always_comb begin
    instret_d = instret_q;
    if (state_q != S_FETCH && state_d == S_FETCH) instret_d = instret_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) instret_q <= '0;
    else          instret_q <= instret_d;
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each step pushes the expected
// control vector for the state the FSM should be in and pops it to compare.
module tb_multicycle_control;

  typedef enum {
    T_RESET, T_FETCH, T_DECODE, T_DEC_ILL, T_MEMADR, T_MEMRD, T_MEMWB,
    T_MEMWR, T_EXECR, T_EXECI, T_ALUWB, T_BEQ, T_JAL
  } tst_e;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] ECALL = 7'b1110011;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] opcode;
  logic       zero;
  logic       ir_write, pc_write, reg_write, illegal_instr;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
`ifdef INSTRET_CNT_EN
  logic [3:0] instret;
`endif

  int checks = 0;
  int errors = 0;
  logic [14:0] sb[$];

  multicycle_control_if mif ();

  multicycle_control #(
`ifdef INSTRET_CNT_EN
    .CNT_W(4)
`else
    .CNT_W(32)
`endif
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .opcode        (opcode),
    .zero          (zero),
    .mem           (mif.master),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .result_src    (result_src),
    .illegal_instr (illegal_instr)
`ifdef INSTRET_CNT_EN
    ,
    .instret       (instret)
`endif
  );

  always #5 clk = ~clk;

  // {req, wr, adr, irw, pcw, regw, srca, srcb, aluop, res, illegal}
  function automatic logic [14:0] exp_out(input tst_e st, input logic rdy, input logic z);
    logic req = 0, wr = 0, adr = 0, irw = 0, pcw = 0, rw = 0, ill = 0;
    logic [1:0] sa = 2'b00, sb_ = 2'b00, op = 2'b00, res = 2'b00;
    case (st)
      T_FETCH:   begin req = 1; irw = rdy; pcw = rdy; sb_ = 2'b10; res = 2'b10; end
      T_DECODE:  begin sa = 2'b01; sb_ = 2'b01; end
      T_DEC_ILL: begin sa = 2'b01; sb_ = 2'b01; ill = 1; end
      T_MEMADR:  begin sa = 2'b10; sb_ = 2'b01; end
      T_MEMRD:   begin req = 1; adr = 1; end
      T_MEMWB:   begin res = 2'b01; rw = 1; end
      T_MEMWR:   begin req = 1; wr = 1; adr = 1; end
      T_EXECR:   begin sa = 2'b10; sb_ = 2'b00; op = 2'b10; end
      T_EXECI:   begin sa = 2'b10; sb_ = 2'b01; op = 2'b10; end
      T_ALUWB:   begin rw = 1; end
      T_BEQ:     begin sa = 2'b10; op = 2'b01; pcw = z; end
      T_JAL:     begin sa = 2'b01; sb_ = 2'b10; pcw = 1; end
      default:   ;
    endcase
    return {req, wr, adr, irw, pcw, rw, sa, sb_, op, res, ill};
  endfunction

  task automatic chk(input string tag);
    logic [14:0] obs, exp;
    obs = {mif.mem_req, mif.mem_write, mif.adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src, illegal_instr};
    exp = sb.pop_front();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive inputs mid-low-phase, check before the rising edge, then advance.
  task automatic step(input tst_e st, input logic [6:0] op, input logic z,
                      input logic rdy, input string tag);
    opcode = op; zero = z; mif.mem_ready = rdy;
    sb.push_back(exp_out(st, rdy, z));
    #2;
    chk(tag);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; opcode = ADD; zero = 1'b0; mif.mem_ready = 1'b1;
    #2;
    sb.push_back(exp_out(T_RESET, 1'b1, 1'b0));
    chk("reset_outputs_zero");
    @(negedge clk);
    reset_n = 1'b1;

    // add, memory always ready
    step(T_FETCH,  ADD, 0, 1, "add_fetch");
    step(T_DECODE, ADD, 0, 1, "add_decode");
    step(T_EXECR,  ADD, 0, 1, "add_execr");
    step(T_ALUWB,  ADD, 0, 1, "add_aluwb");

    // lw: 2 fetch waits, 3 read waits
    step(T_FETCH,  LW, 0, 0, "lw_fetch_wait1");
    step(T_FETCH,  LW, 0, 0, "lw_fetch_wait2");
    step(T_FETCH,  LW, 0, 1, "lw_fetch_rdy");
    step(T_DECODE, LW, 0, 1, "lw_decode_rdy_ignored");
    step(T_MEMADR, LW, 0, 1, "lw_memadr");
    step(T_MEMRD,  LW, 0, 0, "lw_memrd_wait1");
    step(T_MEMRD,  LW, 0, 0, "lw_memrd_wait2");
    step(T_MEMRD,  LW, 0, 0, "lw_memrd_wait3");
    step(T_MEMRD,  LW, 0, 1, "lw_memrd_rdy");
    step(T_MEMWB,  LW, 0, 1, "lw_memwb_cycle10");

    // beq taken and not taken
    step(T_FETCH,  BEQ, 1, 1, "beq1_fetch");
    step(T_DECODE, BEQ, 1, 1, "beq1_decode");
    step(T_BEQ,    BEQ, 1, 1, "beq1_taken");
    step(T_FETCH,  BEQ, 0, 1, "beq0_fetch");
    step(T_DECODE, BEQ, 0, 1, "beq0_decode");
    step(T_BEQ,    BEQ, 0, 1, "beq0_not_taken");

    // unsupported opcode
    step(T_FETCH,   ECALL, 0, 1, "ill_fetch");
    step(T_DEC_ILL, ECALL, 0, 1, "ill_decode_pulse");

    // sw, addi, jal
    step(T_FETCH,  SW, 0, 1, "sw_fetch_after_ill");
    step(T_DECODE, SW, 0, 1, "sw_decode");
    step(T_MEMADR, SW, 0, 1, "sw_memadr");
    step(T_MEMWR,  SW, 0, 1, "sw_memwr_rdy");
    step(T_FETCH,  ADDI, 0, 1, "addi_fetch");
    step(T_DECODE, ADDI, 0, 1, "addi_decode");
    step(T_EXECI,  ADDI, 0, 1, "addi_execi");
    step(T_ALUWB,  ADDI, 0, 1, "addi_aluwb");
    step(T_FETCH,  JAL, 0, 1, "jal_fetch");
    step(T_DECODE, JAL, 0, 1, "jal_decode");
    step(T_JAL,    JAL, 0, 1, "jal_jal");
    step(T_ALUWB,  JAL, 0, 1, "jal_aluwb");

    // reset in the middle of a store wait
    step(T_FETCH,  SW, 0, 1, "swr_fetch");
    step(T_DECODE, SW, 0, 1, "swr_decode");
    step(T_MEMADR, SW, 0, 0, "swr_memadr");
    step(T_MEMWR,  SW, 0, 0, "swr_memwr_wait1");
    sb.push_back(exp_out(T_MEMWR, 1'b0, 1'b0));
    #1 chk("swr_memwr_wait2");
    #1 reset_n = 1'b0;
    sb.push_back(exp_out(T_RESET, 1'b0, 1'b0));
    #1 chk("swr_reset_async_drop");
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step(T_FETCH,  ADD, 0, 1, "post_reset_fetch");
    step(T_DECODE, ADD, 0, 1, "post_reset_decode");

`ifdef INSTRET_CNT_EN
    reset_n = 1'b0;
    #1;
    checks++;
    assert (instret === 4'd0) else begin
      errors++;
      $error("FAIL instret_reset observed=%0d expected=0", instret);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      step(T_FETCH,  BEQ, 0, 1, "cnt_fetch");
      step(T_DECODE, BEQ, 0, 1, "cnt_decode");
      step(T_BEQ,    BEQ, 0, 1, "cnt_beq");
    end
    checks++;
    assert (instret === 4'd1) else begin
      errors++;
      $error("FAIL instret_wrap observed=%0d expected=1", instret);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
